// File: rtl/pcxt_chipset.sv
// Reduced PC/XT chipset core: 8288-style bus command generator, XT I/O and
// video-memory chip-select decoder, PPI port B and DMA page registers.
module pcxt_chipset #(
    parameter logic [19:0] VRAM_BASE = 20'hB8000,
    parameter logic [19:0] VRAM_LAST = 20'hBBFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_data_bus,
    input  logic [2:0]  processor_status,
    input  logic        processor_lock_n,
    input  logic        io_channel_ready,
    input  logic [7:0]  data_bus_ext,
    input  logic [7:0]  port_c_in,
    output logic        processor_ready,
    output logic        bus_lock_n,
    output logic [19:0] address,
    output logic        address_latch_enable,
    output logic [7:0]  data_bus,
    output logic [7:0]  cpu_read_data,
    output logic        io_read_n,
    output logic        io_write_n,
    output logic        memory_read_n,
    output logic        memory_write_n,
    output logic        interrupt_acknowledge_n,
    output logic        cs_dma_n,
    output logic        cs_pic_n,
    output logic        cs_pit_n,
    output logic        cs_ppi_n,
    output logic        cs_page_n,
    output logic        cs_vram_n,
    output logic [7:0]  port_b_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_T1   = 2'd1;
    localparam logic [1:0] ST_CMD  = 2'd2;

    localparam logic [2:0] STATUS_PASSIVE = 3'b111;

    logic [1:0] state;
    logic [2:0] prev_status;
    logic [2:0] status_q;
    logic       first_cmd;
    // Command bits: {inta, ior, iow, memr, memw}; chip selects: {dma, pic, pit, ppi, page, vram}
    logic [4:0] cmd_q;
    logic [5:0] cs_q;
    logic [3:0] page1;
    logic [3:0] page2;
    logic [3:0] page3;

    logic       is_inta;
    logic       is_ior;
    logic       is_iow;
    logic       is_memr;
    logic       is_memw;
    logic       vram_hit;
    logic [4:0] cmd_next;
    logic [5:0] cs_next;
    logic [7:0] read_value;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        is_inta  = (status_q == 3'b000);
        is_ior   = (status_q == 3'b001);
        is_iow   = (status_q == 3'b010);
        is_memr  = (status_q == 3'b100) || (status_q == 3'b101);
        is_memw  = (status_q == 3'b110);
        vram_hit = (address >= VRAM_BASE) && (address <= VRAM_LAST);

        cmd_next = ~{is_inta, is_ior, is_iow, is_memr, is_memw};

        cs_next = 6'h3F;
        if (is_ior || is_iow) begin
            case (address[9:5])
                5'd0:    cs_next[5] = 1'b0;
                5'd1:    cs_next[4] = 1'b0;
                5'd2:    cs_next[3] = 1'b0;
                5'd3:    cs_next[2] = 1'b0;
                5'd4:    cs_next[1] = 1'b0;
                default: cs_next    = 6'h3F;
            endcase
        end
        if ((is_memr || is_memw) && vram_hit) begin
            cs_next[0] = 1'b0;
        end

        read_value = data_bus_ext;
        if (is_ior) begin
            case (address[9:0])
                10'h061: read_value = port_b_out;
                10'h062: read_value = port_c_in;
                10'h081: read_value = {4'h0, page1};
                10'h082: read_value = {4'h0, page2};
                10'h083: read_value = {4'h0, page3};
                default: read_value = data_bus_ext;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= ST_IDLE;
            prev_status          <= STATUS_PASSIVE;
            status_q             <= STATUS_PASSIVE;
            first_cmd            <= 1'b0;
            cmd_q                <= 5'h1F;
            cs_q                 <= 6'h3F;
            address              <= 20'h0;
            address_latch_enable <= 1'b0;
            data_bus             <= 8'h0;
            cpu_read_data        <= 8'h0;
            port_b_out           <= 8'h0;
            page1                <= 4'h0;
            page2                <= 4'h0;
            page3                <= 4'h0;
            processor_ready      <= 1'b0;
            bus_lock_n           <= 1'b1;
        end else begin
            prev_status     <= processor_status;
            processor_ready <= io_channel_ready;
            bus_lock_n      <= processor_lock_n;
            first_cmd       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A cycle starts only on the passive-to-active edge of the status lines.
                    if (processor_status != STATUS_PASSIVE && prev_status == STATUS_PASSIVE) begin
                        state                <= ST_T1;
                        address_latch_enable <= 1'b1;
                        address              <= cpu_address;
                        status_q             <= processor_status;
                    end
                end
                ST_T1: begin
                    state                <= ST_CMD;
                    address_latch_enable <= 1'b0;
                    first_cmd            <= 1'b1;
                    cmd_q                <= cmd_next;
                    cs_q                 <= cs_next;
                end
                ST_CMD: begin
                    if (processor_status == STATUS_PASSIVE) begin
                        state <= ST_IDLE;
                        cmd_q <= 5'h1F;
                        cs_q  <= 6'h3F;
                    end

                    if (is_iow || is_memw) begin
                        data_bus <= cpu_data_bus;
                    end
                    // Registers take only the first CMD cycle's data: one write per bus cycle.
                    if (first_cmd && is_iow) begin
                        case (address[9:0])
                            10'h061: port_b_out <= cpu_data_bus;
                            10'h081: page1      <= cpu_data_bus[3:0];
                            10'h082: page2      <= cpu_data_bus[3:0];
                            10'h083: page3      <= cpu_data_bus[3:0];
                            default: ;
                        endcase
                    end

                    if (is_ior || is_memr || is_inta) begin
                        cpu_read_data <= read_value;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign {interrupt_acknowledge_n, io_read_n, io_write_n, memory_read_n, memory_write_n} = cmd_q;
    assign {cs_dma_n, cs_pic_n, cs_pit_n, cs_ppi_n, cs_page_n, cs_vram_n} = cs_q;

endmodule

// File: tb/tb_pcxt_chipset.sv
// Directed-vector bench for pcxt_chipset: bus cycles of every command type,
// decode boundaries, register write/readback and reset abort.
module tb_pcxt_chipset;

    localparam logic [4:0] CMD_NONE = 5'b11111;
    localparam logic [4:0] CMD_INTA = 5'b01111;
    localparam logic [4:0] CMD_IOR  = 5'b10111;
    localparam logic [4:0] CMD_IOW  = 5'b11011;
    localparam logic [4:0] CMD_MEMR = 5'b11101;
    localparam logic [4:0] CMD_MEMW = 5'b11110;

    localparam logic [5:0] CS_NONE = 6'b111111;
    localparam logic [5:0] CS_DMA  = 6'b011111;
    localparam logic [5:0] CS_PIC  = 6'b101111;
    localparam logic [5:0] CS_PIT  = 6'b110111;
    localparam logic [5:0] CS_PPI  = 6'b111011;
    localparam logic [5:0] CS_PAGE = 6'b111101;
    localparam logic [5:0] CS_VRAM = 6'b111110;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_data_bus;
    logic [2:0]  processor_status;
    logic        processor_lock_n;
    logic        io_channel_ready;
    logic [7:0]  data_bus_ext;
    logic [7:0]  port_c_in;
    logic        processor_ready;
    logic        bus_lock_n;
    logic [19:0] address;
    logic        address_latch_enable;
    logic [7:0]  data_bus;
    logic [7:0]  cpu_read_data;
    logic        io_read_n, io_write_n, memory_read_n, memory_write_n, interrupt_acknowledge_n;
    logic        cs_dma_n, cs_pic_n, cs_pit_n, cs_ppi_n, cs_page_n, cs_vram_n;
    logic [7:0]  port_b_out;

    logic [4:0] cmds;
    logic [5:0] css;
    assign cmds = {interrupt_acknowledge_n, io_read_n, io_write_n, memory_read_n, memory_write_n};
    assign css  = {cs_dma_n, cs_pic_n, cs_pit_n, cs_ppi_n, cs_page_n, cs_vram_n};

    int checks = 0;
    int errors = 0;

    pcxt_chipset dut (
        .clock                  (clock),
        .reset                  (reset),
        .cpu_address            (cpu_address),
        .cpu_data_bus           (cpu_data_bus),
        .processor_status       (processor_status),
        .processor_lock_n       (processor_lock_n),
        .io_channel_ready       (io_channel_ready),
        .data_bus_ext           (data_bus_ext),
        .port_c_in              (port_c_in),
        .processor_ready        (processor_ready),
        .bus_lock_n             (bus_lock_n),
        .address                (address),
        .address_latch_enable   (address_latch_enable),
        .data_bus               (data_bus),
        .cpu_read_data          (cpu_read_data),
        .io_read_n              (io_read_n),
        .io_write_n             (io_write_n),
        .memory_read_n          (memory_read_n),
        .memory_write_n         (memory_write_n),
        .interrupt_acknowledge_n(interrupt_acknowledge_n),
        .cs_dma_n               (cs_dma_n),
        .cs_pic_n               (cs_pic_n),
        .cs_pit_n               (cs_pit_n),
        .cs_ppi_n               (cs_ppi_n),
        .cs_page_n              (cs_page_n),
        .cs_vram_n              (cs_vram_n),
        .port_b_out             (port_b_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge, well clear of it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One bus cycle with status held active for 4 edges, then passive.
    task automatic run_cycle(input string tag, input logic [2:0] st, input logic [19:0] addr,
                             input logic [7:0] wd, input logic [4:0] cmd_exp, input logic [5:0] cs_exp);
        processor_status = st;
        cpu_address      = addr;
        cpu_data_bus     = wd;
        tick();
        check({tag, " ale_t1"}, address_latch_enable, 1'b1);
        check({tag, " addr"}, address, addr);
        check({tag, " cmd_t1"}, cmds, CMD_NONE);
        cpu_address = 20'hFFFFF;
        tick();
        check({tag, " ale_cmd"}, address_latch_enable, 1'b0);
        check({tag, " cmd"}, cmds, cmd_exp);
        check({tag, " cs"}, css, cs_exp);
        tick();
        tick();
        check({tag, " cmd_hold"}, cmds, cmd_exp);
        check({tag, " cs_hold"}, css, cs_exp);
        processor_status = 3'b111;
        tick();
        check({tag, " cmd_end"}, cmds, CMD_NONE);
        check({tag, " cs_end"}, css, CS_NONE);
    endtask

    initial begin
        reset            = 1'b1;
        cpu_address      = 20'h0;
        cpu_data_bus     = 8'h0;
        processor_status = 3'b111;
        processor_lock_n = 1'b0;
        io_channel_ready = 1'b1;
        data_bus_ext     = 8'hA5;
        port_c_in        = 8'h00;
        tick();
        tick();
        check("rst cmd", cmds, CMD_NONE);
        check("rst cs", css, CS_NONE);
        check("rst ale", address_latch_enable, 1'b0);
        check("rst addr", address, 20'h0);
        check("rst data_bus", data_bus, 8'h0);
        check("rst read", cpu_read_data, 8'h0);
        check("rst port_b", port_b_out, 8'h0);
        check("rst ready", processor_ready, 1'b0);
        check("rst lock", bus_lock_n, 1'b1);

        reset = 1'b0;
        tick();
        check("ready follows", processor_ready, 1'b1);
        check("lock follows", bus_lock_n, 1'b0);
        io_channel_ready = 1'b0;
        processor_lock_n = 1'b1;
        tick();
        check("ready drops", processor_ready, 1'b0);
        check("lock drops", bus_lock_n, 1'b1);

        run_cycle("ior_12345", 3'b001, 20'h12345, 8'h00, CMD_IOR, CS_NONE);
        check("ior_12345 rd", cpu_read_data, 8'hA5);

        run_cycle("iow_061", 3'b010, 20'h00061, 8'h55, CMD_IOW, CS_PPI);
        check("iow_061 port_b", port_b_out, 8'h55);
        check("iow_061 data_bus", data_bus, 8'h55);
        run_cycle("ior_061", 3'b001, 20'h00061, 8'h00, CMD_IOR, CS_PPI);
        check("ior_061 rd", cpu_read_data, 8'h55);

        port_c_in = 8'hCC;
        run_cycle("ior_062", 3'b001, 20'h00062, 8'h00, CMD_IOR, CS_PPI);
        check("ior_062 rd", cpu_read_data, 8'hCC);

        run_cycle("iow_083", 3'b010, 20'h00083, 8'h01, CMD_IOW, CS_PAGE);
        run_cycle("iow_081", 3'b010, 20'h00081, 8'h02, CMD_IOW, CS_PAGE);
        run_cycle("iow_082", 3'b010, 20'h00082, 8'h03, CMD_IOW, CS_PAGE);
        run_cycle("ior_083", 3'b001, 20'h00083, 8'h00, CMD_IOR, CS_PAGE);
        check("ior_083 rd", cpu_read_data, 8'h01);
        run_cycle("ior_081", 3'b001, 20'h00081, 8'h00, CMD_IOR, CS_PAGE);
        check("ior_081 rd", cpu_read_data, 8'h02);
        run_cycle("ior_082", 3'b001, 20'h00082, 8'h00, CMD_IOR, CS_PAGE);
        check("ior_082 rd", cpu_read_data, 8'h03);

        run_cycle("ior_000", 3'b001, 20'hFFC00, 8'h00, CMD_IOR, CS_DMA);
        run_cycle("ior_020", 3'b001, 20'h00020, 8'h00, CMD_IOR, CS_PIC);
        run_cycle("ior_05f", 3'b001, 20'h0005F, 8'h00, CMD_IOR, CS_PIT);
        run_cycle("ior_09f", 3'b001, 20'h0009F, 8'h00, CMD_IOR, CS_PAGE);
        data_bus_ext = 8'h3C;
        run_cycle("ior_0a0", 3'b001, 20'h000A0, 8'h00, CMD_IOR, CS_NONE);
        check("ior_0a0 rd", cpu_read_data, 8'h3C);

        run_cycle("memw_b8000", 3'b110, 20'hB8000, 8'h01, CMD_MEMW, CS_VRAM);
        check("memw_b8000 data_bus", data_bus, 8'h01);
        run_cycle("memr_bbfff", 3'b101, 20'hBBFFF, 8'h00, CMD_MEMR, CS_VRAM);
        check("memr_bbfff rd", cpu_read_data, 8'h3C);
        run_cycle("memr_bc000", 3'b100, 20'hBC000, 8'h00, CMD_MEMR, CS_NONE);
        run_cycle("memr_b7fff", 3'b100, 20'hB7FFF, 8'h00, CMD_MEMR, CS_NONE);
        run_cycle("memr_061", 3'b100, 20'h00061, 8'h00, CMD_MEMR, CS_NONE);
        check("memr_061 rd", cpu_read_data, 8'h3C);

        run_cycle("halt", 3'b011, 20'h00000, 8'h00, CMD_NONE, CS_NONE);

        data_bus_ext = 8'h08;
        run_cycle("inta", 3'b000, 20'h00000, 8'h00, CMD_INTA, CS_NONE);
        check("inta rd", cpu_read_data, 8'h08);

        // Reset lands before the first CMD-cycle register load.
        processor_status = 3'b010;
        cpu_address      = 20'h00061;
        cpu_data_bus     = 8'hAA;
        tick();
        tick();
        check("abort cmd", cmds, CMD_IOW);
        reset = 1'b1;
        tick();
        check("abort iow_n", io_write_n, 1'b1);
        check("abort cs", css, CS_NONE);
        check("abort port_b", port_b_out, 8'h00);
        check("abort data_bus", data_bus, 8'h00);
        processor_status = 3'b111;
        reset = 1'b0;
        tick();
        run_cycle("post_rst", 3'b010, 20'h00061, 8'h77, CMD_IOW, CS_PPI);
        check("post_rst port_b", port_b_out, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
